// File: rtl/pause_fade.sv
// Pause controller: merges request/OSD/user-button pause sources into a registered CPU halt,
// and progressively dims the pixel stream while paused.
module pause_fade #(
  parameter int RW         = 8,
  parameter int GW         = 8,
  parameter int BW         = 8,
  parameter int CLKSPD     = 12,
  parameter int MS_CYCLES  = CLKSPD * 1000,
  parameter int NREQ       = 2,
  parameter int DEB_MS     = 4,
  parameter int DIM_SECS   = 10,
  parameter int STEP_SECS  = 1,
  parameter int FADE_STEPS = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  cpu_reset,
  input  logic                  user_button,
  input  logic [NREQ-1:0]       pause_request,
  input  logic [NREQ-1:0]       req_mask,
  input  logic [1:0]            options,
  input  logic                  OSD_STATUS,
  input  logic [RW-1:0]         r,
  input  logic [GW-1:0]         g,
  input  logic [BW-1:0]         b,
  output logic                  pause_cpu,
  output logic [2:0]            pause_src,
  output logic [1:0]            dim_level,
  output logic [RW+GW+BW-1:0]   rgb_out
);

  localparam int PRE_W = $clog2(MS_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_FADE} fade_state_t;

  logic [PRE_W-1:0]       r_pre;
  logic [9:0]             r_ms;
  logic [1:0]             r_sync;
  logic                   r_sync_q;
  logic [3:0]             r_deb_cnt;
  logic                   r_deb;
  logic                   r_toggle;
  logic                   r_pause;
  logic [2:0]             r_src;
  fade_state_t            r_state;
  logic [7:0]             r_sec_cnt;
  logic [1:0]             r_dim;
  logic [RW+GW+BW-1:0]    r_rgb;

  logic                   w_ms_tick;
  logic                   w_sec_tick;
  logic                   w_stable;
  logic                   w_deb_done;
  logic                   w_press;
  logic                   w_req_hit;
  logic                   w_osd_hit;
  logic [1:0]             w_dim_eff;

  assign w_ms_tick  = (r_pre == PRE_W'(MS_CYCLES - 1));
  assign w_sec_tick = w_ms_tick && (r_ms == 10'd999);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else begin
      r_pre <= w_ms_tick ? '0 : r_pre + 1'b1;
      if (w_ms_tick)
        r_ms <= (r_ms == 10'd999) ? '0 : r_ms + 10'd1;
    end
  end

  assign w_stable   = (r_sync[1] == r_sync_q);
  assign w_deb_done = (r_deb_cnt == 4'(DEB_MS)) && w_stable;
  assign w_press    = w_deb_done && r_sync_q && !r_deb;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_sync_q  <= 1'b0;
      r_deb_cnt <= '0;
      r_deb     <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], user_button};
      r_sync_q <= r_sync[1];
      if (!w_stable)
        r_deb_cnt <= '0;
      else if (w_ms_tick && (r_deb_cnt != 4'(DEB_MS)))
        r_deb_cnt <= r_deb_cnt + 4'd1;
      if (w_deb_done)
        r_deb <= r_sync_q;
      // CPU reset wins over a press landing in the same cycle
      if (cpu_reset)
        r_toggle <= 1'b0;
      else if (w_press)
        r_toggle <= ~r_toggle;
    end
  end

  assign w_req_hit = |(pause_request & req_mask);
  assign w_osd_hit = OSD_STATUS & options[0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pause <= 1'b0;
      r_src   <= '0;
    end else begin
      r_pause <= (w_req_hit | w_osd_hit | r_toggle) & ~cpu_reset;
      r_src   <= {r_toggle, w_osd_hit, w_req_hit} & {3{~cpu_reset}};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_RUN;
      r_sec_cnt <= '0;
      r_dim     <= '0;
    end else if (!r_pause || !options[1]) begin
      r_state   <= S_RUN;
      r_sec_cnt <= '0;
      r_dim     <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_sec_cnt <= '0;
          r_dim     <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (r_sec_cnt == 8'(DIM_SECS)) begin
            r_dim     <= 2'd1;
            r_sec_cnt <= '0;
            r_state   <= S_FADE;
          end else if (w_sec_tick) begin
            r_sec_cnt <= r_sec_cnt + 8'd1;
          end
        end
        S_FADE: begin
          if (r_sec_cnt == 8'(STEP_SECS)) begin
            r_sec_cnt <= '0;
            if (r_dim < 2'(FADE_STEPS))
              r_dim <= r_dim + 2'd1;
          end else if (w_sec_tick) begin
            r_sec_cnt <= r_sec_cnt + 8'd1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Gate on the registered pause so un-dimming lands one cycle ahead of the FSM clearing r_dim
  assign w_dim_eff = (r_pause && options[1]) ? r_dim : 2'd0;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      r_rgb <= '0;
    else
      r_rgb <= {r >> w_dim_eff, g >> w_dim_eff, b >> w_dim_eff};
  end

  assign pause_cpu = r_pause;
  assign pause_src = r_src;
  assign dim_level = r_dim;
  assign rgb_out   = r_rgb;

endmodule
